inst_fetch: RTL and testbench
=============================

INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 The block SHALL have the following ports, clock and reset first, in the order given below.
  clk  in  1  clock; all state updates on rising edge.
  rstn  in  1  reset, asynchronous, active-low.
  stall  in  1  decode stage cannot accept; hold the output slot.
  redirect_valid  in  1  branch/jump taken; restart fetch at redirect_pc.
  redirect_pc  in  32  new fetch address; bits [1:0] ignored, forced to 0.
  imem_req  out  1  instruction memory request valid.
  imem_addr  out  32  word-aligned request address.
  imem_ready  in  1  memory accepts the request this cycle.
  imem_rvalid  in  1  response valid; responses return in request order, at least 1 cycle after acceptance.
  imem_rdata  in  32  response instruction word.
  inst_valid  out  1  instruction/pc hold a valid fetched instruction.
  instruction  out  32  fetched instruction word, registered.
  pc  out  32  address of instruction, registered.
  pc_plus_4  out  32  pc + 4, combinational from pc.
REQ-002 Parameter RESET_PC, default 32'hBFC0_0000, SHALL be the first fetch address after reset.

Function
REQ-003 fetch_pc SHALL drive imem_addr and SHALL advance by 4, modulo 2^32, on each accepted request (imem_req && imem_ready).
REQ-004 imem_req SHALL be 1 only when redirect_valid=0 and (outstanding + buffer count) < DEPTH.
REQ-005 outstanding SHALL increment on request acceptance, decrement on imem_rvalid, and be unchanged when both occur in the same cycle.
REQ-006 A non-discarded response SHALL load the output register directly when the buffer is empty and the slot is free (inst_valid=0 or stall=0), giving inst_valid=1 in the cycle after imem_rvalid.
REQ-007 Otherwise a non-discarded response SHALL be written to the tail of the in-order buffer.
REQ-008 The buffer SHALL never overflow, guaranteed by REQ-004.
REQ-009 When the slot is free and the buffer is non-empty, the head entry SHALL pop into the output register; the head takes priority over a same-cycle response, which goes to the buffer.
REQ-010 pc of each instruction SHALL equal the address sent with its request.
REQ-011 When stall=1, instruction, pc and inst_valid SHALL hold their values.
REQ-012 When stall=0 and no data is available, inst_valid SHALL go to 0 on the next edge.
REQ-013 On redirect_valid=1, on the next edge: fetch_pc <= {redirect_pc[31:2],2'b00}; buffer flushed; inst_valid <= 0, regardless of stall.
REQ-014 On redirect, drop_cnt SHALL be set to outstanding minus any response returning in that same cycle; that same-cycle response SHALL be discarded.
REQ-015 While drop_cnt>0, each imem_rvalid SHALL be discarded and SHALL decrement drop_cnt, with no change to the buffer or outputs.
REQ-016 A redirect while drop_cnt>0 SHALL add the current non-dropped outstanding count to drop_cnt.
REQ-017 Back-to-back redirects SHALL each apply; the last one wins.

Reset
REQ-018 While rstn=0: fetch_pc=RESET_PC; outstanding, drop_cnt and buffer count = 0; inst_valid=0; instruction=0; pc=0; imem_req=0.
REQ-019 The first request SHALL be issued in the first cycle after rstn deasserts.
REQ-020 Reset asserted mid-operation SHALL abandon all in-flight requests; the memory is reset concurrently.

Configuration
REQ-021 With macro FETCH_BUF_EN defined, DEPTH=2: a 2-entry buffer, up to 2 requests outstanding.
REQ-022 Without FETCH_BUF_EN, DEPTH=1: a single buffer entry, at most 1 request outstanding, and no issue in a cycle where a response returns unless the buffer is empty.
REQ-023 Functional ordering and redirect behaviour SHALL be identical in both configurations; only throughput differs.

Verification
REQ-024 Reset release with imem_ready=1 and 1-cycle latency -> addresses BFC00000, BFC00004, BFC00008; inst_valid from cycle 2; pc matches each address; pc_plus_4 = pc+4.
REQ-025 stall=1 for 5 cycles with FETCH_BUF_EN -> outputs frozen; imem_req drops after 2 in flight; after release, instructions appear in order with no loss or duplication.
REQ-026 redirect_pc=0x80001003 with 2 outstanding -> next imem_addr=0x80001000; the next 2 responses are discarded; the first inst_valid has pc=0x80001000.
REQ-027 redirect in the same cycle as imem_rvalid and stall=1 -> the response is discarded; inst_valid=0 next cycle; imem_req=0 during the redirect cycle.
REQ-028 imem_ready=0 for 4 cycles -> imem_addr held stable; fetch_pc not advanced; no response consumed.
REQ-029 Redirect to 0xFFFFFFFC -> requests FFFFFFFC, then 00000000 (wrap-around).

Source files
------------

// File: rtl/inst_fetch.sv
// In-order instruction fetch front end: issues word requests, absorbs responses into a small
// buffer, and presents one registered instruction/pc pair to decode. Define FETCH_BUF_EN for two-deep fetch.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] instruction,
  output logic [31:0] pc,
  output logic [31:0] pc_plus_4
);

`ifdef FETCH_BUF_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif
  localparam logic [2:0] DEPTH_L = 3'(DEPTH);

  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] exp_pc_q, exp_pc_d;
  logic [1:0]  outstanding_q, outstanding_d;
  logic [1:0]  drop_cnt_q, drop_cnt_d;
  logic [1:0]  buf_cnt_q, buf_cnt_d;
  logic [31:0] buf_inst_q [DEPTH];
  logic [31:0] buf_inst_d [DEPTH];
  logic [31:0] buf_pc_q [DEPTH];
  logic [31:0] buf_pc_d [DEPTH];
  logic        valid_q, valid_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] pc_q, pc_d;

  logic        accept, slot_free, drop_rsp, keep_rsp, pop, direct, push;
  logic [1:0]  wr_idx;
  logic        unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  // Dropped responses still count as outstanding, so the issue limit also bounds the buffer.
  assign imem_req  = rstn && !redirect_valid &&
                     (({1'b0, outstanding_q} + {1'b0, buf_cnt_q}) < DEPTH_L);
  assign imem_addr = fetch_pc_q;
  assign accept    = imem_req && imem_ready;
  assign slot_free = !valid_q || !stall;
  assign drop_rsp  = imem_rvalid && (redirect_valid || (drop_cnt_q != 2'd0));
  assign keep_rsp  = imem_rvalid && !drop_rsp;
  assign pop       = slot_free && (buf_cnt_q != 2'd0);
  assign direct    = keep_rsp && (buf_cnt_q == 2'd0) && slot_free;
  assign push      = keep_rsp && !direct;
  assign wr_idx    = buf_cnt_q - {1'b0, pop};

  assign inst_valid  = valid_q;
  assign instruction = inst_q;
  assign pc          = pc_q;
  assign pc_plus_4   = pc_q + 32'd4;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    exp_pc_d      = exp_pc_q;
    outstanding_d = outstanding_q + {1'b0, accept} - {1'b0, imem_rvalid};
    drop_cnt_d    = drop_cnt_q;
    buf_cnt_d     = buf_cnt_q + {1'b0, push} - {1'b0, pop};
    buf_inst_d    = buf_inst_q;
    buf_pc_d      = buf_pc_q;
    valid_d       = valid_q;
    inst_d        = inst_q;
    pc_d          = pc_q;

    if (accept) fetch_pc_d = fetch_pc_q + 32'd4;
    if (keep_rsp) exp_pc_d = exp_pc_q + 32'd4;
    if (imem_rvalid && (drop_cnt_q != 2'd0)) drop_cnt_d = drop_cnt_q - 2'd1;

    // Buffer is a shift queue: entry 0 is always the head.
    for (int i = 0; i < DEPTH; i++) begin
      if (pop && (i < DEPTH - 1)) begin
        buf_inst_d[i] = buf_inst_q[(i + 1) % DEPTH];
        buf_pc_d[i]   = buf_pc_q[(i + 1) % DEPTH];
      end
      if (push && (int'(wr_idx) == i)) begin
        buf_inst_d[i] = imem_rdata;
        buf_pc_d[i]   = exp_pc_q;
      end
    end

    if (pop) begin
      valid_d = 1'b1;
      inst_d  = buf_inst_q[0];
      pc_d    = buf_pc_q[0];
    end else if (direct) begin
      valid_d = 1'b1;
      inst_d  = imem_rdata;
      pc_d    = exp_pc_q;
    end else if (slot_free) begin
      valid_d = 1'b0;
    end

    // Everything still in flight at a redirect belongs to the old path.
    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      exp_pc_d   = {redirect_pc[31:2], 2'b00};
      drop_cnt_d = outstanding_q - {1'b0, imem_rvalid};
      buf_cnt_d  = 2'd0;
      valid_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fetch_pc_q    <= RESET_PC;
      exp_pc_q      <= RESET_PC;
      outstanding_q <= 2'd0;
      drop_cnt_q    <= 2'd0;
      buf_cnt_q     <= 2'd0;
      valid_q       <= 1'b0;
      inst_q        <= 32'd0;
      pc_q          <= 32'd0;
      for (int i = 0; i < DEPTH; i++) begin
        buf_inst_q[i] <= 32'd0;
        buf_pc_q[i]   <= 32'd0;
      end
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      exp_pc_q      <= exp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      buf_cnt_q     <= buf_cnt_d;
      valid_q       <= valid_d;
      inst_q        <= inst_d;
      pc_q          <= pc_d;
      buf_inst_q    <= buf_inst_d;
      buf_pc_q      <= buf_pc_d;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch with an in-order memory model whose data is address ^ KEY,
// so every delivered instruction can be paired with the pc it should carry.
module tb_inst_fetch;

  localparam logic [31:0] KEY = 32'hDEAD_BEEF;
`ifdef FETCH_BUF_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic        inst_valid;
  logic [31:0] instruction, pc, pc_plus_4;

  int checkCount = 0;
  int passCount = 0;

  bit          respEn = 1'b1;
  logic [31:0] memQ[$];
  logic [31:0] reqLog[$];
  logic [31:0] gotPc[$];
  logic [31:0] gotInst[$];
  logic        mAcc, mRv;
  logic [31:0] mAddr;

  inst_fetch dut (
    .clk(clk), .rstn(rstn), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .instruction(instruction), .pc(pc), .pc_plus_4(pc_plus_4)
  );

  always #5 clk = ~clk;

  // Memory: responds in order, one cycle after acceptance at the earliest, only while respEn is set.
  initial forever begin
    @(negedge clk);
    mAcc  = rstn && imem_req && imem_ready;
    mAddr = imem_addr;
    mRv   = imem_rvalid;
    @(posedge clk);
    #2;
    if (!rstn) begin
      memQ.delete();
      imem_rvalid = 1'b0;
    end else begin
      if (mRv && (memQ.size() > 0)) void'(memQ.pop_front());
      if (mAcc) memQ.push_back(mAddr);
      if (respEn && (memQ.size() > 0)) begin
        imem_rvalid = 1'b1;
        imem_rdata  = memQ[0] ^ KEY;
      end else begin
        imem_rvalid = 1'b0;
        imem_rdata  = 32'd0;
      end
    end
  end

  // Logs accepted requests and instructions consumed by decode.
  initial forever begin
    @(negedge clk);
    if (rstn && imem_req && imem_ready) reqLog.push_back(imem_addr);
    if (rstn && inst_valid && !stall) begin
      gotPc.push_back(pc);
      gotInst.push_back(instruction);
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [31:0] qAt(input logic [31:0] q[$], input int i);
    if (i < q.size()) return q[i];
    return 'x;
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clearLogs();
    reqLog.delete();
    gotPc.delete();
    gotInst.delete();
  endtask

  task automatic waitGot(input int n);
    for (int c = 0; (c < 40) && (gotPc.size() < n); c++) @(negedge clk);
  endtask

  task automatic test_reset();
    rstn = 1'b0; imem_ready = 1'b1; respEn = 1'b1;
    step(2);
    @(negedge clk);
    checkCount++; if (imem_req !== 1'b0) $display("[TB] FAIL reset_req: got %b expected 0", imem_req); else passCount++;
    checkCount++; if (inst_valid !== 1'b0) $display("[TB] FAIL reset_valid: got %b expected 0", inst_valid); else passCount++;
    checkCount++; if (instruction !== 32'd0) $display("[TB] FAIL reset_inst: got %h expected 0", instruction); else passCount++;
    checkCount++; if (pc !== 32'd0) $display("[TB] FAIL reset_pc: got %h expected 0", pc); else passCount++;
    checkCount++; if (imem_addr !== 32'hBFC0_0000) $display("[TB] FAIL reset_addr: got %h expected bfc00000", imem_addr); else passCount++;
  endtask

  task automatic test_startup();
    clearLogs();
    @(posedge clk); #1;
    rstn = 1'b1;
    @(negedge clk);
    checkCount++; if (imem_req !== 1'b1) $display("[TB] FAIL start_req: got %b expected 1", imem_req); else passCount++;
    checkCount++; if (imem_addr !== 32'hBFC0_0000) $display("[TB] FAIL start_addr: got %h expected bfc00000", imem_addr); else passCount++;
    @(negedge clk);
    checkCount++; if (inst_valid !== 1'b0) $display("[TB] FAIL start_valid_c1: got %b expected 0", inst_valid); else passCount++;
    @(negedge clk);
    checkCount++; if (inst_valid !== 1'b1) $display("[TB] FAIL start_valid_c2: got %b expected 1", inst_valid); else passCount++;
    checkCount++; if (pc !== 32'hBFC0_0000) $display("[TB] FAIL start_pc: got %h expected bfc00000", pc); else passCount++;
    checkCount++; if (instruction !== (32'hBFC0_0000 ^ KEY)) $display("[TB] FAIL start_inst: got %h expected %h", instruction, 32'hBFC0_0000 ^ KEY); else passCount++;
    checkCount++; if (pc_plus_4 !== 32'hBFC0_0004) $display("[TB] FAIL start_pc4: got %h expected bfc00004", pc_plus_4); else passCount++;
    step(8);
    for (int i = 0; i < 3; i++) begin
      checkCount++;
      if (qAt(reqLog, i) !== 32'hBFC0_0000 + 32'(4 * i)) $display("[TB] FAIL start_req_addr%0d: got %h expected %h", i, qAt(reqLog, i), 32'hBFC0_0000 + 32'(4 * i));
      else passCount++;
      checkCount++;
      if (qAt(gotPc, i) !== 32'hBFC0_0000 + 32'(4 * i)) $display("[TB] FAIL start_got_pc%0d: got %h expected %h", i, qAt(gotPc, i), 32'hBFC0_0000 + 32'(4 * i));
      else passCount++;
    end
  endtask

  task automatic test_stall();
    logic [31:0] expPc;
    int bad;
    @(posedge clk); #1;
    stall = 1'b1;
    step(2);
    expPc = 32'hBFC0_0000 + 32'(4 * gotPc.size());
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkCount++;
      if ((inst_valid !== 1'b1) || (pc !== expPc) || (instruction !== (expPc ^ KEY)))
        $display("[TB] FAIL stall_hold%0d: got v=%b pc=%h inst=%h expected v=1 pc=%h inst=%h", c, inst_valid, pc, instruction, expPc, expPc ^ KEY);
      else passCount++;
      if (c < 2) begin @(posedge clk); #1; end
    end
    checkCount++; if (imem_req !== 1'b0) $display("[TB] FAIL stall_req_drop: got %b expected 0", imem_req); else passCount++;
    @(posedge clk); #1;
    stall = 1'b0;
    step(12);
    checkCount++;
    if (gotPc.size() < 8) $display("[TB] FAIL stall_progress: got %0d instructions expected at least 8", gotPc.size());
    else passCount++;
    bad = -1;
    for (int i = 0; i < gotPc.size(); i++)
      if ((bad < 0) && ((gotPc[i] !== 32'hBFC0_0000 + 32'(4 * i)) || (gotInst[i] !== (gotPc[i] ^ KEY)))) bad = i;
    checkCount++;
    if (bad >= 0) $display("[TB] FAIL stall_stream: index %0d got pc=%h inst=%h expected pc=%h", bad, gotPc[bad], gotInst[bad], 32'hBFC0_0000 + 32'(4 * bad));
    else passCount++;
  endtask

  task automatic test_redirect();
    @(posedge clk); #1;
    respEn = 1'b0;
    step(4);
    @(negedge clk);
    checkCount++; if (memQ.size() != DEPTH) $display("[TB] FAIL redir_inflight: got %0d expected %0d", memQ.size(), DEPTH); else passCount++;
    checkCount++; if (imem_req !== 1'b0) $display("[TB] FAIL redir_limit_req: got %b expected 0", imem_req); else passCount++;
    @(posedge clk); #1;
    redirect_valid = 1'b1; redirect_pc = 32'h8000_1003;
    @(negedge clk);
    checkCount++; if (imem_req !== 1'b0) $display("[TB] FAIL redir_req: got %b expected 0", imem_req); else passCount++;
    @(posedge clk); #1;
    redirect_valid = 1'b0; respEn = 1'b1;
    clearLogs();
    @(negedge clk);
    checkCount++; if (imem_addr !== 32'h8000_1000) $display("[TB] FAIL redir_addr: got %h expected 80001000", imem_addr); else passCount++;
    checkCount++; if (inst_valid !== 1'b0) $display("[TB] FAIL redir_valid: got %b expected 0", inst_valid); else passCount++;
    waitGot(2);
    checkCount++; if (qAt(gotPc, 0) !== 32'h8000_1000) $display("[TB] FAIL redir_first_pc: got %h expected 80001000", qAt(gotPc, 0)); else passCount++;
    checkCount++; if (qAt(gotInst, 0) !== (32'h8000_1000 ^ KEY)) $display("[TB] FAIL redir_first_inst: got %h expected %h", qAt(gotInst, 0), 32'h8000_1000 ^ KEY); else passCount++;
    checkCount++; if (qAt(gotPc, 1) !== 32'h8000_1004) $display("[TB] FAIL redir_second_pc: got %h expected 80001004", qAt(gotPc, 1)); else passCount++;
  endtask

  task automatic test_redirect_stall();
    @(posedge clk); #1;
    stall = 1'b1; respEn = 1'b0;
    step(3);
    @(negedge clk);
    checkCount++; if (memQ.size() == 0) $display("[TB] FAIL rs_inflight: got 0 expected nonzero"); else passCount++;
    @(posedge clk); #1;
    redirect_valid = 1'b1; redirect_pc = 32'h0000_2000; respEn = 1'b1;
    @(negedge clk);
    checkCount++; if (imem_rvalid !== 1'b1) $display("[TB] FAIL rs_rvalid: got %b expected 1", imem_rvalid); else passCount++;
    checkCount++; if (imem_req !== 1'b0) $display("[TB] FAIL rs_req: got %b expected 0", imem_req); else passCount++;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    @(negedge clk);
    checkCount++; if (inst_valid !== 1'b0) $display("[TB] FAIL rs_valid: got %b expected 0", inst_valid); else passCount++;
    @(posedge clk); #1;
    stall = 1'b0;
    clearLogs();
    waitGot(1);
    checkCount++; if (qAt(gotPc, 0) !== 32'h0000_2000) $display("[TB] FAIL rs_first_pc: got %h expected 00002000", qAt(gotPc, 0)); else passCount++;
    checkCount++; if (qAt(gotInst, 0) !== (32'h0000_2000 ^ KEY)) $display("[TB] FAIL rs_first_inst: got %h expected %h", qAt(gotInst, 0), 32'h0000_2000 ^ KEY); else passCount++;
  endtask

  task automatic test_ready_low();
    @(posedge clk); #1;
    imem_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0000_3000;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checkCount++;
      if (imem_addr !== 32'h0000_3000) $display("[TB] FAIL rdy_addr%0d: got %h expected 00003000", c, imem_addr);
      else passCount++;
      if (c < 3) begin @(posedge clk); #1; end
    end
    checkCount++; if (inst_valid !== 1'b0) $display("[TB] FAIL rdy_no_inst: got %b expected 0", inst_valid); else passCount++;
    @(posedge clk); #1;
    imem_ready = 1'b1;
    clearLogs();
    waitGot(2);
    checkCount++; if (qAt(reqLog, 0) !== 32'h0000_3000) $display("[TB] FAIL rdy_first_req: got %h expected 00003000", qAt(reqLog, 0)); else passCount++;
    checkCount++; if (qAt(gotPc, 0) !== 32'h0000_3000) $display("[TB] FAIL rdy_first_pc: got %h expected 00003000", qAt(gotPc, 0)); else passCount++;
    checkCount++; if (qAt(gotPc, 1) !== 32'h0000_3004) $display("[TB] FAIL rdy_second_pc: got %h expected 00003004", qAt(gotPc, 1)); else passCount++;
  endtask

  task automatic test_back_to_back();
    step(2);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_1000;
    @(posedge clk); #1;
    redirect_pc = 32'h0000_2040;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    clearLogs();
    @(negedge clk);
    checkCount++; if (imem_addr !== 32'h0000_2040) $display("[TB] FAIL b2b_addr: got %h expected 00002040", imem_addr); else passCount++;
    waitGot(1);
    checkCount++; if (qAt(reqLog, 0) !== 32'h0000_2040) $display("[TB] FAIL b2b_req: got %h expected 00002040", qAt(reqLog, 0)); else passCount++;
    checkCount++; if (qAt(gotPc, 0) !== 32'h0000_2040) $display("[TB] FAIL b2b_pc: got %h expected 00002040", qAt(gotPc, 0)); else passCount++;
  endtask

  task automatic test_wrap();
    logic        sawTop = 1'b0;
    logic [31:0] topP4 = 'x;
    @(posedge clk); #1;
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    clearLogs();
    for (int c = 0; (c < 40) && (gotPc.size() < 2); c++) begin
      @(negedge clk);
      if (inst_valid && (pc == 32'hFFFF_FFFC)) begin sawTop = 1'b1; topP4 = pc_plus_4; end
    end
    checkCount++; if (qAt(reqLog, 0) !== 32'hFFFF_FFFC) $display("[TB] FAIL wrap_req0: got %h expected fffffffc", qAt(reqLog, 0)); else passCount++;
    checkCount++; if (qAt(reqLog, 1) !== 32'h0000_0000) $display("[TB] FAIL wrap_req1: got %h expected 00000000", qAt(reqLog, 1)); else passCount++;
    checkCount++; if (qAt(gotPc, 1) !== 32'h0000_0000) $display("[TB] FAIL wrap_pc1: got %h expected 00000000", qAt(gotPc, 1)); else passCount++;
    checkCount++; if (qAt(gotInst, 1) !== KEY) $display("[TB] FAIL wrap_inst1: got %h expected %h", qAt(gotInst, 1), KEY); else passCount++;
    checkCount++; if (!sawTop || (topP4 !== 32'h0000_0000)) $display("[TB] FAIL wrap_pc4: got %h (seen=%b) expected 00000000", topP4, sawTop); else passCount++;
  endtask

  task automatic test_reset_midflight();
    step(3);
    rstn = 1'b0;
    @(negedge clk);
    checkCount++; if (imem_req !== 1'b0) $display("[TB] FAIL mid_req: got %b expected 0", imem_req); else passCount++;
    checkCount++; if (inst_valid !== 1'b0) $display("[TB] FAIL mid_valid: got %b expected 0", inst_valid); else passCount++;
    checkCount++; if (imem_addr !== 32'hBFC0_0000) $display("[TB] FAIL mid_addr: got %h expected bfc00000", imem_addr); else passCount++;
    step(2);
    rstn = 1'b1;
    clearLogs();
    waitGot(2);
    checkCount++; if (qAt(reqLog, 0) !== 32'hBFC0_0000) $display("[TB] FAIL mid_first_req: got %h expected bfc00000", qAt(reqLog, 0)); else passCount++;
    checkCount++; if (qAt(gotPc, 0) !== 32'hBFC0_0000) $display("[TB] FAIL mid_first_pc: got %h expected bfc00000", qAt(gotPc, 0)); else passCount++;
    checkCount++; if (qAt(gotPc, 1) !== 32'hBFC0_0004) $display("[TB] FAIL mid_second_pc: got %h expected bfc00004", qAt(gotPc, 1)); else passCount++;
  endtask

  initial begin
    test_reset();
    test_startup();
    test_stall();
    test_redirect();
    test_redirect_stall();
    test_ready_low();
    test_back_to_back();
    test_wrap();
    test_reset_midflight();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
